hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
- Iterative multiply/divide unit; the write-side producer for the HI/LO register file.
- Accepts MULT/MULTU/DIV/DIVU from EX and computes the result over multiple cycles.
- Presents hi/lo with a one-cycle write strobe and wconfig, wired directly to the HI/LO register's we/wconfig/hi_i/lo_i inputs.
- busy stalls the pipeline for the whole operation.

Parameters:
- WIDTH, 32, operand width; the HI/LO result is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- flush  in  1  pipeline flush; aborts any operation in progress.
- busy  out  1  high whenever state is not IDLE.
- hilo_we  out  1  one-cycle write strobe carrying the result.
- wconfig  out  2  HI/LO write enables {hi,lo}; 2'b11 while hilo_we is high, else 2'b00.
- hi_o  out  WIDTH  HI result (product[63:32] or remainder).
- lo_o  out  WIDTH  LO result (product[31:0] or quotient).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, hilo_we=0, wconfig=0, hi_o=0, lo_o=0; internal registers cleared.
- States: IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
- Start accept: start=1 in IDLE at edge E0.
  - Operands latched.
  - op[1]=0 -> MUL; op[1]=1 -> DIV_RUN with the iteration counter set to WIDTH-1.
- MUL: one cycle.
  - Full 2*WIDTH product computed: signed for MULT, unsigned for MULTU.
  - Product registered; next state DONE.
  - hilo_we is high in the cycle after edge E0+2.
- DIV_RUN: radix-2 restoring divide on magnitudes.
  - DIV uses |a| and |b| as unsigned 32-bit; 0x80000000 maps to 0x80000000.
  - DIVU uses a and b raw.
  - One quotient bit per cycle, MSB first; counter decrements; exits to DIV_FIX after WIDTH cycles.
- DIV_FIX: signed fixup for DIV only.
  - Quotient negated iff sign(a) != sign(b).
  - Remainder negated iff a is negative.
  - Result truncates toward zero; remainder carries the sign of the dividend.
  - Next state DONE.
  - hilo_we is high in the cycle after edge E0+WIDTH+2 (E0+34 for WIDTH=32).
- DONE: one cycle.
  - hilo_we=1, wconfig=2'b11, hi_o/lo_o valid.
  - busy=1 during DONE; next state IDLE.
  - A new start is accepted only from IDLE, so back-to-back operations are separated by at least one idle cycle.
- hi_o/lo_o hold the last result until the next DONE; they are only meaningful while hilo_we=1.
- Divide by zero (b=0), both DIV and DIVU:
  - Full latency.
  - Result forced to hi_o=a, lo_o=all-ones, overriding the fixup.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0. No trap.
- start while busy: ignored; operands are not re-latched.
- flush: at the next edge state -> IDLE from any state.
  - No hilo_we is produced for the aborted operation; hi_o/lo_o keep their previous values.
  - flush=1 with start=1 in IDLE: flush wins and the operation is not accepted.
  - flush during DONE: hilo_we is still high that cycle, because outputs are registered; the pipeline kills it downstream.
- Reset mid-operation: immediate return to the reset state; no write strobe.

Optional Feature:
- Macro: HILO_MDU_DIV0_FAST_EN.
- Defined: divide by zero is detected at start accept; state goes directly to DONE, so hilo_we is high in the cycle after E0+1. Result values are unchanged (hi=a, lo=all-ones).
- Not defined: divide by zero takes the full E0+34 latency, as specified above.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> hilo_we in cycle after E0+2; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, wconfig=11; busy high 2 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> hilo_we exactly after E0+34; lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo_o=14, hi_o=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. DIVU 5/0 -> hi_o=5, lo_o=0xFFFFFFFF; latency 34 without the macro, 1 with HILO_MDU_DIV0_FAST_EN.
- DIVU started, flush pulsed at E0+10 -> busy low after the next edge, no hilo_we, hi_o/lo_o unchanged. start pulsed during busy is ignored; the result matches the original operands.
- rst_n dropped mid-divide (asynchronous, between edges) -> busy, hilo_we, hi_o, lo_o go 0 immediately. A subsequent MULT 3*4 gives lo_o=12, hi_o=0.

Source files
------------

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit feeding the HI/LO register file write port.
// Optional macro HILO_MDU_DIV0_FAST_EN: divide-by-zero completes straight from start accept.
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             hilo_we,
    output logic [1:0]       wconfig,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL, DIV_RUN, DIV_FIX, DONE} state_t;

    typedef struct packed {
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state;
    req_t             req;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] hi_r, lo_r;

    // One multiplier serves both signednesses: sign-extend only for MULT.
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH:0]     trial;
    logic               a_neg, b_neg, start_sgn, start_div0;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_q, neg_r, req_div0;

    always_comb begin
        ext_a = {{WIDTH{req.sgn & req.a[WIDTH-1]}}, req.a};
        ext_b = {{WIDTH{req.sgn & req.b[WIDTH-1]}}, req.b};
        prod  = ext_a * ext_b;
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

        start_sgn  = ~op[0];
        a_neg      = start_sgn & a[WIDTH-1];
        b_neg      = start_sgn & b[WIDTH-1];
        a_mag      = a_neg ? (~a + 1'b1) : a;
        b_mag      = b_neg ? (~b + 1'b1) : b;
        start_div0 = op[1] & (b == '0);

        neg_q    = req.sgn & (req.a[WIDTH-1] ^ req.b[WIDTH-1]);
        neg_r    = req.sgn & req.a[WIDTH-1];
        req_div0 = (req.b == '0);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req     <= '0;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            hilo_we <= 1'b0;
            wconfig <= 2'b00;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            // Strobe follows DONE by one edge; a flush in DONE cannot retract it.
            hilo_we <= (state == DONE);
            wconfig <= {2{state == DONE}};
            if (state == DONE) begin
                hi_o <= hi_r;
                lo_o <= lo_r;
            end

            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            req <= '{sgn: start_sgn, a: a, b: b};
                            rem <= '0;
                            quo <= a_mag;
                            dvs <= b_mag;
                            cnt <= CW'(WIDTH - 1);
`ifdef HILO_MDU_DIV0_FAST_EN
                            if (start_div0) begin
                                hi_r  <= a;
                                lo_r  <= '1;
                                state <= DONE;
                            end else begin
                                state <= op[1] ? DIV_RUN : MUL;
                            end
`else
                            state <= op[1] ? DIV_RUN : MUL;
`endif
                        end
                    end
                    MUL: begin
                        {hi_r, lo_r} <= prod;
                        state        <= DONE;
                    end
                    DIV_RUN: begin
                        // Restoring step: keep the subtraction only if it did not borrow.
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= DIV_FIX;
                    end
                    DIV_FIX: begin
                        if (req_div0) begin
                            hi_r <= req.a;
                            lo_r <= '1;
                        end else begin
                            hi_r <= neg_r ? (~rem + 1'b1) : rem;
                            lo_r <= neg_q ? (~quo + 1'b1) : quo;
                        end
                        state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef HILO_MDU_DIV0_FAST_EN
    logic unused_div0;
    assign unused_div0 = start_div0;
`endif

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu (honours HILO_MDU_DIV0_FAST_EN for div-by-zero latency).
module tb_hilo_mdu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, hilo_we;
    logic [1:0]  wconfig;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;

`ifdef HILO_MDU_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 34;
`endif

    hilo_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hilo_we(hilo_we), .wconfig(wconfig),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an op, measures edges from accept to the strobe and busy cycles,
    // then checks result and that the strobe lasts a single cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit inject);
        int lat, bcnt;
        bit seen;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0; seen = 0;
        while (!seen && lat < 60) begin
            if (busy) bcnt++;
            if (inject && lat == 4) begin
                start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (hilo_we) seen = 1;
        end
        start = 1'b0;
        chk({tag, "_seen"}, 72'(seen), 72'(1));
        chk({tag, "_lat"}, 72'(lat), 72'(exp_lat));
        chk({tag, "_busy"}, 72'(bcnt), 72'(exp_lat));
        chk({tag, "_res"}, {8'(wconfig), hi_o, lo_o}, {8'h03, ehi, elo});
        @(posedge clk); #1;
        chk({tag, "_drop"}, 72'({hilo_we, wconfig}), 72'(0));
    endtask

    initial begin
        int ok;
        #12;
        chk("reset", {5'(0), busy, hilo_we, wconfig, hi_o, lo_o}, 72'(0));
        @(negedge clk); rst_n = 1'b1;

        run_op("mult",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("multu",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_nd", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("divu",   2'b11, 32'd100,       32'd7,         34, 32'd2,         32'd14,        0);
        run_op("ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("div0",   2'b11, 32'd5,         32'd0,   DIV0_LAT, 32'd5,         32'hFFFF_FFFF, 0);

        // flush together with start in IDLE: not accepted
        @(negedge clk);
        op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start", 72'(busy), 72'(0));

        // flush at E0+10 mid-divide
        @(negedge clk);
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 72'(busy), 72'(0));
        ok = 1;
        repeat (40) begin
            @(posedge clk); #1;
            if (hilo_we || busy) ok = 0;
        end
        chk("flush_nowe", 72'(ok), 72'(1));
        chk("flush_hold", {8'(0), hi_o, lo_o}, {8'(0), 32'd5, 32'hFFFF_FFFF});

        // start pulsed while busy must not disturb the running divide
        run_op("inject", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1);

        // asynchronous reset between edges mid-divide
        @(negedge clk);
        op = 2'b10; a = 32'd50; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst", {6'(0), busy, hilo_we, hi_o, lo_o}, 72'(0));
        @(negedge clk); rst_n = 1'b1;
        run_op("post_rst", 2'b00, 32'd3, 32'd4, 2, 32'd0, 32'd12, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
